// File: rtl/psram_resp.sv
// PSRAM device-side responder: oversampled DDR byte bus into a small memory.
// Pad inputs are synchronized together, then decoded by a single state machine.
module psram_resp #(
  parameter int MEM_DEPTH  = 64,
  parameter int SYNC_STAGE = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cfg_wcmd_i,
  input  logic [7:0] cfg_rcmd_i,
  input  logic [7:0] cfg_wlc_i,
  input  logic [7:0] cfg_rlc_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic       psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_INST, S_ADDR, S_LATN,
    S_WDATA, S_RDATA, S_DROP
  } state_t;

  logic [10:0]   r_sync [SYNC_STAGE];
  logic          r_sck_d;
  state_t        r_state;
  logic          r_armed;
  logic          r_rd;
  logic [1:0]    r_cnt;
  logic [7:0]    r_lat;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_io_out;
  logic          r_io_en;
  logic          r_dqs_out;
  logic          r_dqs_en;
  logic          r_err;
  logic [7:0]    r_mem [MEM_DEPTH];

  logic [10:0]   w_pad;
  logic [10:0]   w_last;
  logic          w_sck;
  logic          w_ce;
  logic          w_dqs;
  logic [7:0]    w_io;
  logic          w_re;
  logic          w_fe;
  logic          w_astep;
  logic [7:0]    w_lat_sel;
  logic          w_go_data;
  logic [AW-1:0] w_ent_idx;
  logic [AW-1:0] w_idx_inc;

  assign w_pad  = {psram_sck_i, psram_ce_i,
                   psram_dqs_in_i, psram_io_in_i};
  assign w_last = r_sync[SYNC_STAGE-1];
  assign w_sck  = w_last[10];
  assign w_ce   = w_last[9];
  assign w_dqs  = w_last[8];
  assign w_io   = w_last[7:0];
  assign w_re   = w_sck & ~r_sck_d;
  assign w_fe   = ~w_sck & r_sck_d;

  // Address bytes alternate edges: re, fe, re, fe.
  assign w_astep   = r_cnt[0] ? w_fe : w_re;
  assign w_lat_sel = r_rd ? cfg_rlc_i : cfg_wlc_i;
  assign w_idx_inc = r_idx + 1'b1;
  // Only the last address byte reaches the index bits.
  assign w_ent_idx = (r_state == S_ADDR) ?
                     w_io[AW-1:0] : r_idx;
  assign w_go_data =
    ((r_state == S_ADDR) && w_astep &&
     (r_cnt == 2'd3) && (w_lat_sel == 8'd0)) ||
    ((r_state == S_LATN) && w_re && (r_lat == 8'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGE; i++)
        r_sync[i] <= '0;
      r_sck_d <= 1'b0;
    end else begin
      r_sync[0] <= w_pad;
      for (int i = 1; i < SYNC_STAGE; i++)
        r_sync[i] <= r_sync[i-1];
      r_sck_d <= w_sck;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_rd      <= 1'b0;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_idx     <= '0;
      r_io_out  <= '0;
      r_io_en   <= 1'b0;
      r_dqs_out <= 1'b0;
      r_dqs_en  <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_ce) begin
        r_armed   <= 1'b1;
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_io_out  <= '0;
        r_io_en   <= 1'b0;
        r_dqs_out <= 1'b0;
        r_dqs_en  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE:
            if (r_armed) r_state <= S_INST;
          S_INST:
            if (w_re) begin
              r_cnt <= '0;
              if (w_io == cfg_rcmd_i) begin
                r_rd    <= 1'b1;
                r_state <= S_ADDR;
              end else if (w_io == cfg_wcmd_i) begin
                r_rd    <= 1'b0;
                r_state <= S_ADDR;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end
            end
          S_ADDR:
            if (w_astep) begin
              r_cnt <= r_cnt + 2'd1;
              if (r_cnt == 2'd3) begin
                r_idx   <= w_io[AW-1:0];
                r_lat   <= w_lat_sel;
                r_state <= S_LATN;
              end
            end
          S_LATN:
            if (w_re) r_lat <= r_lat - 8'd1;
          S_WDATA:
            if (w_re | w_fe) begin
              if (!w_dqs) r_mem[r_idx] <= w_io;
              r_idx <= w_idx_inc;
            end
          S_RDATA:
            if (w_re | w_fe) begin
              r_idx     <= w_idx_inc;
              r_io_out  <= r_mem[w_idx_inc];
              r_dqs_out <= ~r_dqs_out;
            end
          S_DROP: ;
          default: r_state <= S_IDLE;
        endcase
        if (w_go_data) begin
          if (r_rd) begin
            r_state   <= S_RDATA;
            r_io_en   <= 1'b1;
            r_dqs_en  <= 1'b1;
            r_dqs_out <= 1'b0;
            r_io_out  <= r_mem[w_ent_idx];
          end else begin
            r_state <= S_WDATA;
          end
        end
      end
    end
  end

  assign psram_io_out_o  = r_io_out;
  assign psram_io_en_o   = r_io_en;
  assign psram_dqs_out_o = r_dqs_out;
  assign psram_dqs_en_o  = r_dqs_en;
  assign busy_o          = (r_state != S_IDLE);
  assign err_o           = r_err;

endmodule

// File: tb/tb_psram_resp.sv
// Bench for psram_resp: directed bus transactions with a read-data
// scoreboard checked by an independent monitor.
module tb_psram_resp;

  localparam logic [7:0] WCMD = 8'hA0;
  localparam logic [7:0] RCMD = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wlc = 8'd0;
  logic [7:0] rlc = 8'd0;
  logic       sck = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       io_en;
  logic       dqs_in = 1'b0;
  logic       dqs_out;
  logic       dqs_en;
  logic       busy;
  logic       err;

  int total = 0;
  int bad = 0;
  int tog_cnt = 0;
  int err_n = 0;
  bit en_seen = 1'b0;
  bit win = 1'b0;
  bit p_en = 1'b0;
  bit p_dqs = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] mdl [64];

  psram_resp dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_wcmd_i(WCMD),
    .cfg_rcmd_i(RCMD),
    .cfg_wlc_i(wlc),
    .cfg_rlc_i(rlc),
    .psram_sck_i(sck),
    .psram_ce_i(ce),
    .psram_io_in_i(io_in),
    .psram_io_out_o(io_out),
    .psram_io_en_o(io_en),
    .psram_dqs_in_i(dqs_in),
    .psram_dqs_out_o(dqs_out),
    .psram_dqs_en_o(dqs_en),
    .busy_o(busy),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: each presented read byte pops one expectation.
  always @(negedge clk) begin
    if (io_en && (!p_en || dqs_out != p_dqs)) begin
      if (p_en) tog_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_extra: got %0h want none", io_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (io_out !== e || (!p_en && dqs_out !== 1'b0)) begin
          bad++;
          $display("FAIL rd_byte: got %0h/dqs%0b want %0h",
                   io_out, dqs_out, e);
        end
      end
    end
    if (win) begin
      if (err) err_n++;
      if (io_en) en_seen = 1'b1;
    end
    p_en  = io_en;
    p_dqs = dqs_out;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d, input logic m);
    io_in  = d;
    dqs_in = m;
    tick(1);
    sck = ~sck;
    tick(3);
  endtask

  task automatic start(input logic [7:0] op);
    ce = 1'b0;
    tick(4);
    strobe(op, 1'b0);
    strobe(op, 1'b0);
  endtask

  task automatic send_addr(input logic [7:0] a);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    strobe(a, 1'b0);
  endtask

  // Latency ends on the n-th rising edge.
  task automatic lat_edges(input logic [7:0] n);
    if (n != 0)
      repeat (2 * int'(n) - 1) strobe(8'h00, 1'b0);
  endtask

  task automatic end_txn();
    ce = 1'b1;
    tick(4);
    sck = 1'b0;
    tick(4);
  endtask

  task automatic do_write(input logic [7:0] a,
                          input logic [7:0] d [$],
                          input logic m [$],
                          input logic [7:0] lat);
    wlc = lat;
    start(WCMD);
    send_addr(a);
    lat_edges(lat);
    foreach (d[i]) begin
      strobe(d[i], m[i]);
      if (!m[i]) mdl[(int'(a) + i) % 64] = d[i];
    end
    end_txn();
  endtask

  task automatic do_read(input logic [7:0] a, input int n,
                         input logic [7:0] lat);
    rlc = lat;
    for (int i = 0; i <= n; i++)
      exp_q.push_back(mdl[(int'(a) + i) % 64]);
    tog_cnt = 0;
    start(RCMD);
    send_addr(a);
    lat_edges(lat);
    repeat (n) strobe(8'h00, 1'b0);
    tick(3);
    chk("rd_toggles", tog_cnt, n);
    end_txn();
  endtask

  initial begin
    logic [7:0] d [$];
    logic m [$];
    int cyc;
    foreach (mdl[i]) mdl[i] = 8'h00;
    tick(4);
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_io_en", io_en, 1'b0);
    chk("rst_dqs_out", dqs_out, 1'b0);
    chk("rst_dqs_en", dqs_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick(6);

    d = '{8'h11, 8'h12, 8'h13, 8'h14,
          8'h15, 8'h16, 8'h17, 8'h18};
    m = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_write(8'h10, d, m, 8'd2);
    do_read(8'h10, 8, 8'd3);

    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    m = '{0, 1, 0, 1};
    do_write(8'h20, d, m, 8'd1);
    do_read(8'h20, 3, 8'd2);

    d = '{8'h01, 8'h02, 8'h03};
    m = '{0, 0, 0};
    do_write(8'h3E, d, m, 8'd0);
    do_read(8'h3E, 2, 8'd0);

    // Bad opcode followed by write-like traffic.
    err_n   = 0;
    en_seen = 1'b0;
    win     = 1'b1;
    start(8'h55);
    send_addr(8'h10);
    repeat (6) strobe(8'hEE, 1'b0);
    end_txn();
    win = 1'b0;
    chk("bad_err_cycles", err_n, 1);
    chk("bad_io_en", en_seen, 1'b0);
    do_read(8'h10, 2, 8'd2);

    // Abort after two address bytes.
    start(WCMD);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    ce  = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin
      tick(1);
      cyc++;
    end
    chk("abort_busy_in_time", (cyc <= 4), 1'b1);
    tick(4);
    do_read(8'h3E, 1, 8'd1);

    // Reset during read data.
    rlc = 8'd1;
    exp_q.push_back(mdl[8'h10]);
    exp_q.push_back(mdl[8'h11]);
    exp_q.push_back(mdl[8'h12]);
    start(RCMD);
    send_addr(8'h10);
    lat_edges(8'd1);
    strobe(8'h00, 1'b0);
    strobe(8'h00, 1'b0);
    tick(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_io_en", io_en, 1'b0);
    chk("mid_rst_dqs_en", dqs_en, 1'b0);
    chk("mid_rst_dqs_out", dqs_out, 1'b0);
    ce  = 1'b1;
    sck = 1'b0;
    foreach (mdl[i]) mdl[i] = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(6);
    do_read(8'h10, 1, 8'd1);

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
